// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared widths, event layout and row-state type for the AER event path
package dvs_ravens_pkg;
    localparam int AER_W   = 10;
    localparam int COORD_W = 9;
    localparam int TS_W    = 13;
    localparam int EVT_W   = 32;

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        logic               pol;
    } evt_t;

    typedef enum logic [0:0] {
        NO_ROW   = 1'b0,
        HAVE_ROW = 1'b1
    } row_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/aer_event_builder.sv
// aer_event_builder: pairs AER row/column words into timestamped events and buffers them
module aer_event_builder
    import dvs_ravens_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_PRESCALE = 100
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          word_valid,
    input  logic [AER_W-1:0]              word_data,
    input  logic                          word_xsel,
    output logic [EVT_W-1:0]              evt_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          clr_flags,
    output logic                          overflow,
    output logic [7:0]                    orphan_cnt,
    output logic [7:0]                    drop_cnt
);
    localparam int PW = TS_PRESCALE > 1 ? $clog2(TS_PRESCALE) : 1;

    row_state_e         state_q, state_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         orphan_q, orphan_d, drop_q, drop_d;
    logic               is_y, is_x, evt_push, orphan, drop, ts_tick, fifo_full, fifo_empty;
    evt_t               evt;

    assign is_y     = word_valid && !word_xsel;
    assign is_x     = word_valid && word_xsel;
    assign evt_push = is_x && state_q == HAVE_ROW;
    assign orphan   = is_x && state_q == NO_ROW;
    // full implies non-empty, so a ready downstream frees a slot this same edge
    assign drop     = evt_push && fifo_full && !evt_ready;
    assign ts_tick  = pre_q == PW'(TS_PRESCALE - 1);
    assign evt      = '{ts: ts_q, y: y_q, x: word_data[AER_W-1:1], pol: word_data[0]};

    always_comb begin
        state_d    = is_y ? HAVE_ROW : state_q;
        y_d        = is_y ? word_data[COORD_W-1:0] : y_q;
        pre_d      = ts_tick ? '0 : pre_q + 1'b1;
        ts_d       = ts_tick ? ts_q + 1'b1 : ts_q;
        overflow_d = !clr_flags && (overflow_q || drop);
        orphan_d   = clr_flags ? '0 : orphan_q + 8'(orphan && orphan_q != 8'hFF);
        drop_d     = clr_flags ? '0 : drop_q + 8'(drop && drop_q != 8'hFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NO_ROW;
            y_q        <= '0;
            pre_q      <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            orphan_q   <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            pre_q      <= pre_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            orphan_q   <= orphan_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH(EVT_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (evt_push),
        .pop_i  (evt_ready),
        .din_i  (evt),
        .dout_o (evt_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    assign evt_valid  = !fifo_empty;
    assign overflow   = overflow_q;
    assign orphan_cnt = orphan_q;
    assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_aer_event_builder.sv
// tb_aer_event_builder: directed checks of event forming, FIFO, flags, ts wrap and async reset
module tb_aer_event_builder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        word_valid = 1'b0, word_xsel = 1'b0, evt_ready = 1'b0, clr_flags = 1'b0;
    logic [9:0]  word_data = '0;
    logic [31:0] evt_data;
    logic        evt_valid, overflow;
    logic [3:0]  fifo_count;
    logic [7:0]  orphan_cnt, drop_cnt;
    int          checks = 0, failures = 0;

    aer_event_builder #(.FIFO_DEPTH(8), .TS_PRESCALE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_xsel (word_xsel),
        .evt_data  (evt_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .fifo_count(fifo_count),
        .clr_flags (clr_flags),
        .overflow  (overflow),
        .orphan_cnt(orphan_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [12:0] ts, input logic [8:0] y, input logic [8:0] x, input logic pol);
        return {ts, y, x, pol};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_y(input logic [9:0] w);
        word_valid = 1'b1;
        word_xsel  = 1'b0;
        word_data  = w;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic send_x(input logic [9:0] w);
        word_valid = 1'b1;
        word_xsel  = 1'b1;
        word_data  = w;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst_n      = 1'b0;
        evt_ready  = 1'b0;
        clr_flags  = 1'b0;
        word_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_data", evt_data, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_orphan", 32'(orphan_cnt), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // basic event: Y at ts0, idle at ts1, X at ts2
        do_reset();
        send_y(10'h005);
        tick();
        check("basic_pre_valid", 32'(evt_valid), 32'd0);
        send_x(10'h0C9);
        check("basic_valid", 32'(evt_valid), 32'd1);
        check("basic_data", evt_data, ev(13'd2, 9'd5, 9'd100, 1'b1));
        check("basic_count", 32'(fifo_count), 32'd1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("basic_pop_count", 32'(fifo_count), 32'd0);
        check("basic_pop_valid", 32'(evt_valid), 32'd0);

        // several X words on one row; bit 9 of the Y word must be ignored
        do_reset();
        evt_ready = 1'b1;
        send_y(10'h203);
        for (int k = 1; k <= 3; k++) begin
            send_x({9'(k), 1'b0});
            check("multi_valid", 32'(evt_valid), 32'd1);
            check("multi_data", evt_data, ev(13'(k), 9'd3, 9'(k), 1'b0));
            check("multi_count", 32'(fifo_count), 32'd1);
        end
        tick();
        check("multi_drain", 32'(fifo_count), 32'd0);
        evt_ready = 1'b0;

        // orphans, saturation and clear priority
        do_reset();
        send_x(10'h0C9);
        check("orphan_one", 32'(orphan_cnt), 32'd1);
        check("orphan_no_evt", 32'(evt_valid), 32'd0);
        for (int i = 0; i < 299; i++) send_x(10'h011);
        check("orphan_sat", 32'(orphan_cnt), 32'd255);
        clr_flags = 1'b1;
        send_x(10'h011);
        clr_flags = 1'b0;
        check("orphan_clr_prio", 32'(orphan_cnt), 32'd0);
        send_x(10'h011);
        check("orphan_after_clr", 32'(orphan_cnt), 32'd1);

        // overflow: X k at ts k, ten pushes into depth 8
        do_reset();
        send_y(10'h007);
        for (int k = 1; k <= 10; k++) send_x({9'(k), k[0]});
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_drop", 32'(drop_cnt), 32'd2);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", evt_data, ev(13'd1, 9'd7, 9'd1, 1'b1));
        evt_ready = 1'b1;
        send_x({9'd11, 1'b1});
        check("full_pushpop_count", 32'(fifo_count), 32'd8);
        check("full_pushpop_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            int kk;
            kk = i < 7 ? i + 2 : 11;
            check("ovf_order", evt_data, ev(13'(kk), 9'd7, 9'(kk), kk[0]));
            tick();
        end
        evt_ready = 1'b0;
        check("ovf_empty", 32'(evt_valid), 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_drop", 32'(drop_cnt), 32'd0);

        // ts wrap: one event at ts 8191, the next at ts 0
        do_reset();
        send_y(10'h001);
        repeat (8190) tick();
        send_x({9'd4, 1'b0});
        send_x({9'd5, 1'b1});
        check("wrap_count", 32'(fifo_count), 32'd2);
        check("wrap_last", evt_data, ev(13'd8191, 9'd1, 9'd4, 1'b0));
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("wrap_zero", evt_data, ev(13'd0, 9'd1, 9'd5, 1'b1));

        // asynchronous reset between edges with buffered events and a held row
        do_reset();
        send_y(10'h009);
        for (int k = 1; k <= 5; k++) send_x({9'(k), 1'b1});
        check("mid_count_pre", 32'(fifo_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(evt_valid), 32'd0);
        check("mid_count", 32'(fifo_count), 32'd0);
        check("mid_data", evt_data, 32'd0);
        tick();
        rst_n = 1'b1;
        send_x(10'h0C9);
        check("mid_orphan", 32'(orphan_cnt), 32'd1);
        check("mid_no_evt", 32'(evt_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
